// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared types for the ALU result stage (opcodes, FIFO entry, depth)
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int RES_W      = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_DIF = 3'd1,
    OP_PRO = 3'd2,
    OP_QUO = 3'd3,
    OP_REM = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  // Encoding equals the number of stored entries.
  typedef enum logic [FIFO_CW-1:0] {
    FIFO_EMPTY = FIFO_CW'(0),
    FIFO_ONE   = FIFO_CW'(1),
    FIFO_FULL  = FIFO_CW'(2)
  } fifo_state_e;

  typedef struct packed {
    logic [RES_W-1:0] res;
    alu_op_e          op;
    logic             zero;
    logic             div0;
  } alu_res_t;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_QUO) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_skid_fifo.sv
`default_nettype none
// ============================================================================
// alu_skid_fifo : 2-entry registered FIFO of ALU results, valid/ready both sides
// Revision : 1.0
// ============================================================================
module alu_skid_fifo
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_valid,
  input  alu_res_t i_data,
  output logic     o_ready,
  output logic     o_valid,
  output alu_res_t o_data,
  input  logic     i_ready
);

  fifo_state_e state_q, state_d;
  alu_res_t    head_q, head_d;
  alu_res_t    tail_q, tail_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        w_push;
  logic        w_pop;

  assign w_push = i_valid && in_ready_q;
  assign w_pop  = out_valid_q && i_ready;

  // head_q is the output register, so the data stays put while stalled or empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      FIFO_EMPTY: begin
        if (w_push) begin
          head_d  = i_data;
          state_d = FIFO_ONE;
        end
      end
      FIFO_ONE: begin
        if (w_push && w_pop) begin
          head_d = i_data;
        end else if (w_push) begin
          tail_d  = i_data;
          state_d = FIFO_FULL;
        end else if (w_pop) begin
          state_d = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        if (w_pop) begin
          head_d  = tail_q;
          state_d = FIFO_ONE;
        end
      end
      default: state_d = FIFO_EMPTY;
    endcase
    in_ready_d  = (state_d != FIFO_FULL);
    out_valid_d = (state_d != FIFO_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= FIFO_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_ready = in_ready_q;
  assign o_valid = out_valid_q;
  assign o_data  = head_q;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// alu_result_stage : selects the ALU result by opcode, adds flags, buffers it
// Revision : 1.0
// ============================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DW    = 32,  // must equal RES_W of the FIFO entry
  parameter int CNT_W = 16
) (
  input  logic             clk_d,
  input  logic             rstn_d,
  input  logic [2:0]       op_d,
  input  logic [15:0]      m_d,
  input  logic [DW-1:0]    sum_d,
  input  logic [DW-1:0]    dif_d,
  input  logic [DW-1:0]    pro_d,
  input  logic [DW-1:0]    quo_d,
  input  logic [DW-1:0]    rem_d,
  input  logic [DW-1:0]    and_d,
  input  logic [DW-1:0]    or_d,
  input  logic [DW-1:0]    xor_d,
  input  logic             in_valid_d,
  output logic             in_ready_d,
  output logic [DW-1:0]    res_d,
  output logic             zero_d,
  output logic             div0_d,
  output logic [2:0]       op_out_d,
  output logic             out_valid_d,
  input  logic             out_ready_d,
  output logic [CNT_W-1:0] count_d
);

  alu_op_e          w_op;
  logic [DW-1:0]    w_bus;
  logic             w_div0;
  logic             w_accept;
  alu_res_t         w_entry;
  alu_res_t         w_head;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    w_op  = alu_op_e'(op_d);
    w_bus = '0;
    case (w_op)
      OP_SUM:  w_bus = sum_d;
      OP_DIF:  w_bus = dif_d;
      OP_PRO:  w_bus = pro_d;
      OP_QUO:  w_bus = quo_d;
      OP_REM:  w_bus = rem_d;
      OP_AND:  w_bus = and_d;
      OP_OR:   w_bus = or_d;
      OP_XOR:  w_bus = xor_d;
      default: w_bus = '0;
    endcase
    // A divide by zero stores 0, so the zero flag follows from the stored value.
    w_div0        = is_div_op(w_op) && (m_d == 16'd0);
    w_entry       = '0;
    w_entry.res   = w_div0 ? '0 : w_bus;
    w_entry.op    = w_op;
    w_entry.div0  = w_div0;
    w_entry.zero  = (w_entry.res == '0);
  end

  assign w_accept  = in_valid_d && in_ready_d;
  assign acc_cnt_d = acc_cnt_q + CNT_W'(w_accept);

  always_ff @(posedge clk_d) begin
    if (!rstn_d) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  alu_skid_fifo u_fifo (
    .clk     (clk_d),
    .rstn    (rstn_d),
    .i_valid (in_valid_d),
    .i_data  (w_entry),
    .o_ready (in_ready_d),
    .o_valid (out_valid_d),
    .o_data  (w_head),
    .i_ready (out_ready_d)
  );

  assign res_d    = w_head.res;
  assign zero_d   = w_head.zero;
  assign div0_d   = w_head.div0;
  assign op_out_d = w_head.op;
  assign count_d  = acc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// tb_alu_result_stage : directed scenarios plus randomized traffic checked
// against a queue-based reference model of the result stream.
module tb_alu_result_stage;

  localparam int DW    = 32;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [2:0]    op;
    logic          zero;
    logic          div0;
  } ent_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic [2:0]       op;
  logic [15:0]      m;
  logic [DW-1:0]    bus [8];
  logic             in_valid;
  logic             out_ready;
  logic             in_ready;
  logic [DW-1:0]    res;
  logic             zero;
  logic             div0;
  logic [2:0]       op_out;
  logic             out_valid;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  alu_result_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk_d       (clk),
    .rstn_d      (rstn),
    .op_d        (op),
    .m_d         (m),
    .sum_d       (bus[0]),
    .dif_d       (bus[1]),
    .pro_d       (bus[2]),
    .quo_d       (bus[3]),
    .rem_d       (bus[4]),
    .and_d       (bus[5]),
    .or_d        (bus[6]),
    .xor_d       (bus[7]),
    .in_valid_d  (in_valid),
    .in_ready_d  (in_ready),
    .res_d       (res),
    .zero_d      (zero),
    .div0_d      (div0),
    .op_out_d    (op_out),
    .out_valid_d (out_valid),
    .out_ready_d (out_ready),
    .count_d     (count)
  );

  // Reference model: queue of pending results, last popped value, accept count.
  ent_t             q[$];
  ent_t             hold;
  logic [CNT_W-1:0] m_cnt;
  int               n_checks = 0;
  int               n_pass   = 0;

  function automatic ent_t model_entry();
    ent_t e;
    e.op   = op;
    e.div0 = ((op == 3'd3) || (op == 3'd4)) && (m == 16'd0);
    e.res  = e.div0 ? '0 : bus[op];
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic ent_t exp_head();
    return (q.size() > 0) ? q[0] : hold;
  endfunction

  task automatic rand_inputs();
    op = 3'($urandom_range(0, 7));
    m  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    foreach (bus[k]) bus[k] = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
  endtask

  task automatic tick();
    ent_t e;
    logic acc;
    logic pp;
    e   = model_entry();
    acc = in_valid && (q.size() < 2);
    pp  = out_ready && (q.size() > 0);
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      hold  = '0;
      m_cnt = '0;
    end else begin
      if (pp) hold = q.pop_front();
      if (acc) begin
        q.push_back(e);
        m_cnt = m_cnt + 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_inputs();
    tick(); tick();
    rstn = 1'b1;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL reset_handshake: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if ({res, zero, div0, op_out} !== {32'h0, 1'b0, 1'b0, 3'd0})
      $display("FAIL reset_data: got res=%h z=%b d=%b op=%0d want all 0", res, zero, div0, op_out);
    else n_pass++;
    n_checks++;
    if (count !== 16'd0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
  endtask

  task automatic test_basic();
    rand_inputs();
    op = 3'd0; bus[0] = 32'h0000_0005; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({res, out_valid, zero} !== {32'h5, 1'b1, 1'b0})
      $display("FAIL basic_result: got res=%h v=%b z=%b want res=5 v=1 z=0", res, out_valid, zero);
    else n_pass++;
    n_checks++;
    if (count !== 16'd1) $display("FAIL basic_count: got %0d want 1", count);
    else n_pass++;
    tick();
    n_checks++;
    if ({out_valid, in_ready, res} !== {1'b0, 1'b1, 32'h5})
      $display("FAIL empty_hold: got v=%b r=%b res=%h want v=0 r=1 res=5", out_valid, in_ready, res);
    else n_pass++;
  endtask

  task automatic test_div0();
    rand_inputs();
    op = 3'd3; m = 16'd0; bus[3] = 32'hDEAD_BEEF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({res, div0, zero, op_out} !== {32'h0, 1'b1, 1'b1, 3'd3})
      $display("FAIL div0_quo: got res=%h d=%b z=%b op=%0d want res=0 d=1 z=1 op=3", res, div0, zero, op_out);
    else n_pass++;
    tick();
    op = 3'd4; m = 16'd7; bus[4] = $urandom | 32'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({res, div0, zero, op_out} !== {bus[4], 1'b0, 1'b0, 3'd4})
      $display("FAIL rem_nonzero: got res=%h d=%b z=%b op=%0d want res=%h d=0 z=0 op=4", res, div0, zero, op_out, bus[4]);
    else n_pass++;
    tick();
  endtask

  task automatic test_full();
    ent_t             beat [3];
    logic [CNT_W-1:0] base;
    base = m_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      beat[i] = model_entry();
      in_valid = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== (i == 0))
        $display("FAIL full_ready beat %0d: got %b want %b", i, in_ready, (i == 0));
      else n_pass++;
    end
    in_valid = 1'b0;
    n_checks++;
    if ({count, res, op_out} !== {base + 16'd2, beat[0].res, beat[0].op})
      $display("FAIL full_hold: got cnt=%0d res=%h op=%0d want cnt=%0d res=%h op=%0d",
               count, res, op_out, base + 16'd2, beat[0].res, beat[0].op);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, res, op_out} !== {1'b1, beat[1].res, beat[1].op})
      $display("FAIL full_pop_b: got v=%b res=%h op=%0d want v=1 res=%h op=%0d",
               out_valid, res, op_out, beat[1].res, beat[1].op);
    else n_pass++;
    tick();
    n_checks++;
    if ({out_valid, res} !== {1'b0, beat[1].res})
      $display("FAIL full_drain: got v=%b res=%h want v=0 res=%h", out_valid, res, beat[1].res);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    ent_t             y;
    logic [CNT_W-1:0] base;
    out_ready = 1'b0;
    rand_inputs(); in_valid = 1'b1;
    tick();
    base = m_cnt;
    rand_inputs(); y = model_entry(); out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, res, op_out, count} !== {1'b1, 1'b1, y.res, y.op, base + 16'd1})
      $display("FAIL push_pop: got v=%b r=%b res=%h op=%0d cnt=%0d want v=1 r=1 res=%h op=%0d cnt=%0d",
               out_valid, in_ready, res, op_out, count, y.res, y.op, base + 16'd1);
    else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, res} !== {1'b0, y.res})
      $display("FAIL push_pop_drain: got v=%b res=%h want v=0 res=%h", out_valid, res, y.res);
    else n_pass++;
  endtask

  task automatic test_stall();
    ent_t             f;
    logic [CNT_W-1:0] base;
    out_ready = 1'b0;
    rand_inputs(); f = model_entry(); in_valid = 1'b1;
    tick();
    rand_inputs();
    tick();
    base = m_cnt;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      tick();
      n_checks++;
      if ({out_valid, in_ready, res, op_out, count} !== {1'b1, 1'b0, f.res, f.op, base})
        $display("FAIL stall cyc %0d: got v=%b r=%b res=%h op=%0d cnt=%0d want v=1 r=0 res=%h op=%0d cnt=%0d",
                 i, out_valid, in_ready, res, op_out, count, f.res, f.op, base);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, count, res} !== {1'b0, 1'b1, 16'd0, 32'h0})
      $display("FAIL reset_mid: got v=%b r=%b cnt=%0d res=%h want v=0 r=1 cnt=0 res=0",
               out_valid, in_ready, count, res);
    else n_pass++;
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      h = exp_head();
      n_checks++;
      if ({out_valid, in_ready, res, zero, div0, op_out, count} !==
          {(q.size() > 0), (q.size() < 2), h.res, h.zero, h.div0, h.op, m_cnt})
        $display("FAIL random cyc %0d: got v=%b r=%b res=%h z=%b d=%b op=%0d cnt=%0d want v=%b r=%b res=%h z=%b d=%b op=%0d cnt=%0d",
                 i, out_valid, in_ready, res, zero, div0, op_out, count,
                 (q.size() > 0), (q.size() < 2), h.res, h.zero, h.div0, h.op, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_count_wrap();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
      rand_inputs();
      tick();
    end
    n_checks++;
    if (count !== 16'hFFFF || m_cnt !== 16'hFFFF)
      $display("FAIL count_preload: got %h (model %h) want ffff", count, m_cnt);
    else n_pass++;
    rand_inputs();
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 16'h0000) $display("FAIL count_wrap: got %h want 0000", count);
    else n_pass++;
  endtask

  initial begin
    hold  = '0;
    m_cnt = '0;
    test_reset();
    test_basic();
    test_div0();
    test_full();
    test_push_pop();
    test_stall();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
